match_selector: RTL and testbench

MATCH_SELECTOR -- requirements
Module: match_selector

---
 rtl/match_selector_pkg.sv | 21 ++
 rtl/match_selector.sv | 152 +++++++++++++++
 tb/tb_match_selector.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_selector_pkg.sv
// ---------------------------------------------------------------------------
// match_selector_pkg
// Shared LSH definitions used by input_handler and match_selector.
//   LSH_NUM_WINDOWS : number of stored reference windows (one vote count each)
//   LSH_COUNT_W     : width of one vote count (holds 0..16 hash-table hits)
//   LSH_ID_W        : width of a window ID
//   sel_state_e     : scan FSM states of the match selector
// ---------------------------------------------------------------------------
package match_selector_pkg;

   localparam int LSH_NUM_WINDOWS = 16;
   localparam int LSH_COUNT_W     = 5;
   localparam int LSH_ID_W        = $clog2(LSH_NUM_WINDOWS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } sel_state_e;

endpackage

// File: rtl/match_selector.sv
// ---------------------------------------------------------------------------
// match_selector
// Takes one snapshot of the per-window vote counts, then walks the windows
// one per cycle to find the highest count (lowest ID wins ties) and reports
// whether it reaches the threshold captured with the snapshot.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   countValid : one-cycle pulse, countBus/threshold hold a complete query
//   countBus   : NUM_WINDOWS vote counts, entry i belongs to window i
//   threshold  : minimum count for a declared match
//   busy       : high while a scan (SCAN or DONE) is in progress
//   matchValid : one-cycle pulse, result outputs updated
//   matchFound : best count is non-zero and >= captured threshold
//   matchID    : window with the highest count
//   matchCount : highest count
//   overrun    : sticky, a query arrived while busy (cleared by reset only)
// ---------------------------------------------------------------------------
module match_selector
   import match_selector_pkg::*;
#(
   parameter int NUM_WINDOWS = LSH_NUM_WINDOWS,
   parameter int COUNT_W     = LSH_COUNT_W,
   parameter int ID_W        = $clog2(NUM_WINDOWS)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                countValid,
   input  logic [NUM_WINDOWS-1:0][COUNT_W-1:0] countBus,
   input  logic [COUNT_W-1:0]                  threshold,
   output logic                                busy,
   output logic                                matchValid,
   output logic                                matchFound,
   output logic [ID_W-1:0]                     matchID,
   output logic [COUNT_W-1:0]                  matchCount,
   output logic                                overrun
);

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_WINDOWS - 1);

   sel_state_e                          state_q, state_d;
   logic [NUM_WINDOWS-1:0][COUNT_W-1:0] cap_q, cap_d;
   logic [COUNT_W-1:0]                  thr_q, thr_d;
   logic [COUNT_W-1:0]                  best_count_q, best_count_d;
   logic [ID_W-1:0]                     best_id_q, best_id_d;
   logic [ID_W-1:0]                     scan_idx_q, scan_idx_d;
   logic                                match_valid_q, match_valid_d;
   logic                                match_found_q, match_found_d;
   logic [ID_W-1:0]                     match_id_q, match_id_d;
   logic [COUNT_W-1:0]                  match_count_q, match_count_d;
   logic                                overrun_q, overrun_d;

   // State and datapath registers; reset wins over any query arriving in
   // the same cycle and aborts a scan without producing a result pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cap_q         <= '0;
         thr_q         <= '0;
         best_count_q  <= '0;
         best_id_q     <= '0;
         scan_idx_q    <= '0;
         match_valid_q <= 1'b0;
         match_found_q <= 1'b0;
         match_id_q    <= '0;
         match_count_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cap_q         <= cap_d;
         thr_q         <= thr_d;
         best_count_q  <= best_count_d;
         best_id_q     <= best_id_d;
         scan_idx_q    <= scan_idx_d;
         match_valid_q <= match_valid_d;
         match_found_q <= match_found_d;
         match_id_q    <= match_id_d;
         match_count_q <= match_count_d;
         overrun_q     <= overrun_d;
      end
   end

   // Next-state logic: a scan lasts exactly NUM_WINDOWS cycles and leaves
   // after the last entry rather than wrapping into a second pass.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (countValid) state_d = ST_SCAN;
         ST_SCAN: if (scan_idx_q == LAST_IDX) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output logic. The snapshot decouples the scan from later
   // countBus activity. The strict '>' combined with the ascending scan
   // makes ties resolve to the lowest window ID. A zero best count never
   // counts as a match, even with a zero threshold.
   always_comb begin
      cap_d         = cap_q;
      thr_d         = thr_q;
      best_count_d  = best_count_q;
      best_id_d     = best_id_q;
      scan_idx_d    = scan_idx_q;
      match_valid_d = 1'b0;
      match_found_d = match_found_q;
      match_id_d    = match_id_q;
      match_count_d = match_count_q;
      overrun_d     = overrun_q;

      case (state_q)
         ST_IDLE: begin
            if (countValid) begin
               cap_d        = countBus;
               thr_d        = threshold;
               best_count_d = '0;
               best_id_d    = '0;
               scan_idx_d   = '0;
            end
         end
         ST_SCAN: begin
            if (cap_q[scan_idx_q] > best_count_q) begin
               best_count_d = cap_q[scan_idx_q];
               best_id_d    = scan_idx_q;
            end
            if (scan_idx_q != LAST_IDX) begin
               scan_idx_d = scan_idx_q + ID_W'(1);
            end
         end
         ST_DONE: begin
            match_valid_d = 1'b1;
            match_found_d = (best_count_q != '0) && (best_count_q >= thr_q);
            match_id_d    = best_id_q;
            match_count_d = best_count_q;
         end
         default: ;
      endcase

      if (countValid && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign matchValid = match_valid_q;
   assign matchFound = match_found_q;
   assign matchID    = match_id_q;
   assign matchCount = match_count_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_match_selector.sv
// ---------------------------------------------------------------------------
// tb_match_selector
// Scoreboard bench: each accepted query pushes its expected result; a
// monitor pops and compares whenever matchValid pulses, including latency.
// ---------------------------------------------------------------------------
module tb_match_selector;

   localparam int NW = 16;
   localparam int CW = 5;
   localparam int IW = 4;
   localparam int LATENCY = 17;

   typedef logic [NW-1:0][CW-1:0] bus_t;

   typedef struct {
      logic          found;
      logic [IW-1:0] id;
      logic [CW-1:0] count;
      int            start;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          countValid;
   bus_t          countBus;
   logic [CW-1:0] threshold;
   logic          busy;
   logic          matchValid;
   logic          matchFound;
   logic [IW-1:0] matchID;
   logic [CW-1:0] matchCount;
   logic          overrun;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   cyc;
   int   valid_count;

   match_selector #(
      .NUM_WINDOWS(NW),
      .COUNT_W    (CW),
      .ID_W       (IW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .countValid(countValid),
      .countBus  (countBus),
      .threshold (threshold),
      .busy      (busy),
      .matchValid(matchValid),
      .matchFound(matchFound),
      .matchID   (matchID),
      .matchCount(matchCount),
      .overrun   (overrun)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure result latency
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every result pulse must match the oldest query
   always @(negedge clk) begin
      if (matchValid === 1'b1) begin
         exp_t e;
         valid_count++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_matchValid: got pulse at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            if (matchFound !== e.found) begin
               errors++;
               $display("[TB] FAIL matchFound: got %0b expected %0b", matchFound, e.found);
            end
            checks++;
            if (matchID !== e.id) begin
               errors++;
               $display("[TB] FAIL matchID: got %0d expected %0d", matchID, e.id);
            end
            checks++;
            if (matchCount !== e.count) begin
               errors++;
               $display("[TB] FAIL matchCount: got %0d expected %0d", matchCount, e.count);
            end
            checks++;
            if (cyc - e.start !== LATENCY) begin
               errors++;
               $display("[TB] FAIL latency: got %0d expected %0d", cyc - e.start, LATENCY);
            end
         end
      end
   end

   // Reference: ascending scan, strict compare, zero never matches
   function automatic void ref_model(input bus_t b, input logic [CW-1:0] thr,
                                     output logic f, output logic [IW-1:0] id,
                                     output logic [CW-1:0] c);
      c  = '0;
      id = '0;
      for (int i = 0; i < NW; i++) begin
         if (b[i] > c) begin
            c  = b[i];
            id = IW'(i);
         end
      end
      f = (c != '0) && (c >= thr);
   endfunction

   // Caller sits #1 after a posedge; query is sampled at the next edge
   task automatic applyStimulus(input bus_t b, input logic [CW-1:0] thr, input bit push,
                                input logic f, input logic [IW-1:0] id, input logic [CW-1:0] c);
      exp_t e;
      countBus   = b;
      threshold  = thr;
      countValid = 1'b1;
      @(posedge clk);
      #1;
      countValid = 1'b0;
      if (push) begin
         e.found = f;
         e.id    = id;
         e.count = c;
         e.start = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) sb.delete();
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      countValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({busy, matchValid, matchFound, matchID, matchCount, overrun} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%0b mv=%0b mf=%0b id=%0d cnt=%0d ov=%0b expected all 0",
                  busy, matchValid, matchFound, matchID, matchCount, overrun);
      end
   endtask

   task automatic test_single_match();
      bus_t b;
      bit   ok;
      b = '0;
      b[14] = 5'd9;
      applyStimulus(b, 5'd4, 1'b1, 1'b1, 4'd14, 5'd9);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_in_scan: got %0b expected 1", busy);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL single_timeout: got no result expected one");
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_after_done: got %0b expected 0", busy);
      end
   endtask

   task automatic test_tie();
      bus_t b;
      bit   ok;
      b = '0;
      b[3]  = 5'd7;
      b[10] = 5'd7;
      applyStimulus(b, 5'd2, 1'b1, 1'b1, 4'd3, 5'd7);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL tie_timeout: got no result expected one");
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({matchFound, matchID, matchCount} !== {1'b1, 4'd3, 5'd7}) begin
         errors++;
         $display("[TB] FAIL result_hold: got mf=%0b id=%0d cnt=%0d expected mf=1 id=3 cnt=7",
                  matchFound, matchID, matchCount);
      end
   endtask

   task automatic test_threshold_and_zero();
      bus_t b;
      bit   ok;
      b = '0;
      b[5] = 5'd3;
      applyStimulus(b, 5'd4, 1'b1, 1'b0, 4'd5, 5'd3);
      wait_drain(ok);
      b = '0;
      applyStimulus(b, 5'd0, 1'b1, 1'b0, 4'd0, 5'd0);
      wait_drain(ok);
      b = '0;
      b[15] = 5'd31;
      applyStimulus(b, 5'd31, 1'b1, 1'b1, 4'd15, 5'd31);
      wait_drain(ok);
      b = '0;
      b[0] = 5'd1;
      applyStimulus(b, 5'd1, 1'b1, 1'b1, 4'd0, 5'd1);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL threshold_timeout: got no result expected one");
      end
   endtask

   task automatic test_back_to_back();
      bus_t b;
      bit   seen;
      bit   ok;
      b = '0;
      b[8] = 5'd12;
      applyStimulus(b, 5'd5, 1'b1, 1'b1, 4'd8, 5'd12);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (matchValid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL b2b_first_timeout: got no matchValid expected one");
      end
      b = '0;
      b[11] = 5'd4;
      b[12] = 5'd6;
      applyStimulus(b, 5'd7, 1'b1, 1'b0, 4'd12, 5'd6);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL b2b_second_timeout: got no result expected one");
      end
   endtask

   task automatic test_overrun();
      bus_t b;
      bit   ok;
      int   pulses;
      b = '0;
      b[2] = 5'd6;
      pulses = valid_count;
      applyStimulus(b, 5'd1, 1'b1, 1'b1, 4'd2, 5'd6);
      repeat (3) @(posedge clk);
      #1;
      b = '0;
      b[9] = 5'd20;
      applyStimulus(b, 5'd1, 1'b0, 1'b0, 4'd0, 5'd0);
      wait_drain(ok);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (valid_count - pulses !== 1) begin
         errors++;
         $display("[TB] FAIL overrun_pulses: got %0d expected 1", valid_count - pulses);
      end
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_sticky: got %0b expected 1", overrun);
      end
      do_reset();
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overrun_cleared: got %0b expected 0", overrun);
      end
   endtask

   task automatic test_reset_mid_scan();
      bus_t b;
      bit   ok;
      int   pulses;
      b = '0;
      b[7] = 5'd12;
      pulses = valid_count;
      applyStimulus(b, 5'd2, 1'b0, 1'b0, 4'd0, 5'd0);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({busy, matchValid, matchFound, matchID, matchCount, overrun} !== '0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs: got busy=%0b mv=%0b mf=%0b id=%0d cnt=%0d ov=%0b expected all 0",
                  busy, matchValid, matchFound, matchID, matchCount, overrun);
      end
      repeat (25) @(posedge clk);
      #1;
      checks++;
      if (valid_count !== pulses) begin
         errors++;
         $display("[TB] FAIL mid_reset_pulse: got %0d pulses expected 0", valid_count - pulses);
      end
      b = '0;
      b[1] = 5'd2;
      applyStimulus(b, 5'd2, 1'b1, 1'b1, 4'd1, 5'd2);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL post_reset_timeout: got no result expected one");
      end
   endtask

   task automatic test_capture_isolation();
      bus_t b;
      bit   ok;
      b = '0;
      b[6] = 5'd10;
      applyStimulus(b, 5'd3, 1'b1, 1'b1, 4'd6, 5'd10);
      repeat (2) @(posedge clk);
      #1;
      countBus[0]  = 5'd16;
      countBus[13] = 5'd30;
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL isolation_timeout: got no result expected one");
      end
   endtask

   task automatic test_random();
      bus_t          b;
      logic [CW-1:0] thr;
      logic          f;
      logic [IW-1:0] id;
      logic [CW-1:0] c;
      bit            ok;
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < NW; i++) b[i] = CW'($urandom_range(0, 16));
         thr = CW'($urandom_range(0, 17));
         ref_model(b, thr, f, id, c);
         applyStimulus(b, thr, 1'b1, f, id, c);
         wait_drain(ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("[TB] FAIL random_timeout: got no result expected one");
         end
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      valid_count = 0;
      reset       = 1'b1;
      countValid  = 1'b0;
      countBus    = '0;
      threshold   = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single_match();
      test_tie();
      test_threshold_and_zero();
      test_back_to_back();
      test_overrun();
      test_reset_mid_scan();
      test_capture_isolation();
      test_random();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
